hazard_unit: RTL



---
 rtl/aww_types_pkg.sv | 21 ++
 rtl/sat_counter.sv | 31 +++
 rtl/hazard_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/aww_types_pkg.sv
// aww_types_pkg: shared pipeline control types for the five-stage core.
`default_nettype none

package aww_types_pkg;

  typedef enum logic [1:0] {
    NO_STALL   = 2'b00,
    IFID_STALL = 2'b01,
    IDEX_STALL = 2'b10,
    FULL_STALL = 2'b11
  } pipe_stall_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    SQUASH = 2'b01,
    HALT   = 2'b10
  } hazard_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds at MAX.
`default_nettype none

module sat_counter #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  assign at_max = (count == MAX);

  // Clear wins over increment so an idle cycle always restarts the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the five-stage pipeline, with
// halt tracking, memory-wait watchdog and stall-cycle counter.
`default_nettype none

module hazard_unit
  import aww_types_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dmem_req,
  input  logic             idex_dREN,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_jump,
  input  logic             exmem_branch_taken,
  input  logic             memwb_halt,
  output pipe_stall_t      pipe_stall,
  output logic             pc_en,
  output logic             ifid_FLUSH,
  output logic             idex_FLUSH,
  output logic             exmem_FLUSH,
  output logic             memwb_FLUSH,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WD_W = 16;

  hazard_state_t state, next_state;

  logic dwait;
  logic lduse;
  logic wd_wait;
  logic wd_at_max;
  logic [WD_W-1:0] wait_cnt;
  logic err_q;
  logic stall_inc;
  logic stall_at_max;

  assign dwait = exmem_dmem_req & ~dhit;
  assign lduse = idex_dREN & (idex_rd != 5'd0) &
                 ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));

  assign memwb_FLUSH = 1'b0;
  assign halted      = (state == HALT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    pipe_stall  = NO_STALL;
    pc_en       = 1'b0;
    ifid_FLUSH  = 1'b0;
    idex_FLUSH  = 1'b0;
    exmem_FLUSH = 1'b0;

    unique case (state)
      RUN: begin
        if (dwait) begin
          pipe_stall = FULL_STALL;
        end else if (exmem_branch_taken) begin
          pc_en       = 1'b1;
          ifid_FLUSH  = 1'b1;
          idex_FLUSH  = 1'b1;
          exmem_FLUSH = 1'b1;
          // PC moves to the target now; the outstanding fetch is wrong-path.
          if (!ihit) next_state = SQUASH;
        end else if (lduse) begin
          pipe_stall = IDEX_STALL;
        end else if (!ihit) begin
          pipe_stall = IFID_STALL;
        end else begin
          pc_en      = 1'b1;
          ifid_FLUSH = ifid_jump;
        end
      end
      SQUASH: begin
        pipe_stall = dwait ? FULL_STALL : IFID_STALL;
        if (ihit) begin
          ifid_FLUSH = 1'b1;
          next_state = RUN;
        end
      end
      HALT: begin
        pipe_stall = FULL_STALL;
      end
      default: begin
        pipe_stall = FULL_STALL;
        next_state = RUN;
      end
    endcase

    if (memwb_halt) next_state = HALT;

    if (RST) begin
      pipe_stall  = FULL_STALL;
      pc_en       = 1'b0;
      ifid_FLUSH  = 1'b0;
      idex_FLUSH  = 1'b0;
      exmem_FLUSH = 1'b0;
    end
  end

  // Fetch waits are meaningless once halted; data waits still count.
  assign wd_wait = dwait | (~ihit & (state != HALT));

  sat_counter #(
    .WIDTH (WD_W),
    .MAX   (WD_W'(MEM_TIMEOUT))
  ) u_watchdog (
    .CLK    (CLK),
    .RST    (RST),
    .inc    (wd_wait),
    .clr    (~wd_wait),
    .count  (wait_cnt),
    .at_max (wd_at_max)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | wd_at_max;
    end
  end

  assign timeout_err = err_q | wd_at_max;

  assign stall_inc = (pipe_stall != NO_STALL) & (state != HALT);

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   ({CNT_W{1'b1}})
  ) u_stall_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .inc    (stall_inc),
    .clr    (1'b0),
    .count  (stall_cycles),
    .at_max (stall_at_max)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, stall_at_max, wait_cnt};

endmodule

`default_nettype wire
